// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// combinational fetch-stage lookup and execute-stage update, plus branch/mispredict counters.
module branch_target_buffer #(
  parameter int unsigned IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        UpdValidE,
  input  logic [31:0] UpdPCE,
  input  logic        UpdTakenE,
  input  logic [31:0] UpdTargetE,
  input  logic        UpdMispredE,
  output logic [31:0] BrCount,
  output logic [31:0] MispredCount
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_W   = 30 - IDX_W;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  ctr_e               ctr_q    [ENTRIES];
  ctr_e               ctr_d    [ENTRIES];
  logic [31:0]        br_count_q, br_count_d;
  logic [31:0]        mis_count_q, mis_count_d;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{PCF[1:0], UpdPCE[1:0]};

  function automatic ctr_e sat_inc(input ctr_e c);
    case (c)
      SNT:     sat_inc = WNT;
      WNT:     sat_inc = WT;
      default: sat_inc = ST;
    endcase
  endfunction

  function automatic ctr_e sat_dec(input ctr_e c);
    case (c)
      ST:      sat_dec = WT;
      WT:      sat_dec = WNT;
      default: sat_dec = SNT;
    endcase
  endfunction

  // Fetch-side lookup reads the registered table, so a same-cycle update is not visible yet.
  always_comb begin
    f_idx       = PCF[IDX_W+1:2];
    f_tag       = PCF[31:IDX_W+2];
    f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    PredTakenF  = f_hit && ctr_q[f_idx][1];
    PredTargetF = f_hit ? target_q[f_idx] : '0;
  end

  always_comb begin
    u_idx       = UpdPCE[IDX_W+1:2];
    u_tag       = UpdPCE[31:IDX_W+2];
    u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    valid_d     = valid_q;
    tag_d       = tag_q;
    target_d    = target_q;
    ctr_d       = ctr_q;
    br_count_d  = br_count_q;
    mis_count_d = mis_count_q;
    if (UpdValidE) begin
      br_count_d = br_count_q + 32'd1;
      if (UpdMispredE) begin
        mis_count_d = mis_count_q + 32'd1;
      end
      if (u_hit) begin
        if (UpdTakenE) begin
          ctr_d[u_idx]    = sat_inc(ctr_q[u_idx]);
          target_d[u_idx] = UpdTargetE;
        end else begin
          ctr_d[u_idx] = sat_dec(ctr_q[u_idx]);
        end
      end else if (UpdTakenE) begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = UpdTargetE;
        ctr_d[u_idx]    = WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      ctr_q       <= '{default: SNT};
      br_count_q  <= '0;
      mis_count_q <= '0;
    end else begin
      valid_q     <= valid_d;
      ctr_q       <= ctr_d;
      br_count_q  <= br_count_d;
      mis_count_q <= mis_count_d;
    end
  end

  // Tag and target are meaningless while valid is clear, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign BrCount      = br_count_q;
  assign MispredCount = mis_count_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed-vector bench for branch_target_buffer with hand-computed expectations.
module tb_branch_target_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        UpdValidE;
  logic [31:0] UpdPCE;
  logic        UpdTakenE;
  logic [31:0] UpdTargetE;
  logic        UpdMispredE;
  logic [31:0] BrCount;
  logic [31:0] MispredCount;

  int unsigned n_vec;
  int unsigned n_bad;

  branch_target_buffer #(.IDX_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .PCF         (PCF),
    .PredTakenF  (PredTakenF),
    .PredTargetF (PredTargetF),
    .UpdValidE   (UpdValidE),
    .UpdPCE      (UpdPCE),
    .UpdTakenE   (UpdTakenE),
    .UpdTargetE  (UpdTargetE),
    .UpdMispredE (UpdMispredE),
    .BrCount     (BrCount),
    .MispredCount(MispredCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic mis);
    UpdValidE   = 1'b1;
    UpdPCE      = pc;
    UpdTakenE   = taken;
    UpdTargetE  = tgt;
    UpdMispredE = mis;
    step();
    UpdValidE   = 1'b0;
    UpdMispredE = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_taken,
                      input logic [31:0] exp_tgt);
    PCF = pc;
    #1;
    chk({tag, ".taken"}, {31'b0, PredTakenF}, {31'b0, exp_taken});
    chk({tag, ".target"}, PredTargetF, exp_tgt);
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    PCF         = '0;
    UpdValidE   = 1'b0;
    UpdPCE      = '0;
    UpdTakenE   = 1'b0;
    UpdTargetE  = '0;
    UpdMispredE = 1'b0;
    step();
    step();
    rst = 1'b0;

    look("reset_lookup", 32'h0000_0010, 1'b0, 32'h0);
    chk("reset_br", BrCount, 32'd0);
    chk("reset_mis", MispredCount, 32'd0);

    // Allocation
    upd(32'h0000_0010, 1'b1, 32'h0000_0040, 1'b1);
    look("alloc", 32'h0000_0010, 1'b1, 32'h0000_0040);
    chk("alloc_ctr", 32'(dut.ctr_q[4]), 32'd2);
    chk("alloc_br", BrCount, 32'd1);
    chk("alloc_mis", MispredCount, 32'd1);

    // Hysteresis
    upd(32'h0000_0010, 1'b0, 32'h0000_0000, 1'b1);
    look("hyst_nt", 32'h0000_0010, 1'b0, 32'h0000_0040);
    chk("hyst_nt_ctr", 32'(dut.ctr_q[4]), 32'd1);
    upd(32'h0000_0010, 1'b1, 32'h0000_0040, 1'b0);
    chk("hyst_t1_ctr", 32'(dut.ctr_q[4]), 32'd2);
    upd(32'h0000_0010, 1'b1, 32'h0000_0040, 1'b0);
    chk("hyst_t2_ctr", 32'(dut.ctr_q[4]), 32'd3);
    upd(32'h0000_0010, 1'b1, 32'h0000_0040, 1'b0);
    chk("hyst_sat_ctr", 32'(dut.ctr_q[4]), 32'd3);
    look("hyst_sat", 32'h0000_0010, 1'b1, 32'h0000_0040);
    chk("hyst_br", BrCount, 32'd5);
    chk("hyst_mis", MispredCount, 32'd2);

    // Aliasing: 0x50 shares index 4 with 0x10
    upd(32'h0000_0050, 1'b1, 32'h0000_0080, 1'b1);
    look("alias_old", 32'h0000_0010, 1'b0, 32'h0);
    look("alias_new", 32'h0000_0050, 1'b1, 32'h0000_0080);
    chk("alias_ctr", 32'(dut.ctr_q[4]), 32'd2);
    upd(32'h0000_0010, 1'b0, 32'h0000_0123, 1'b0);
    look("nt_miss_keep", 32'h0000_0050, 1'b1, 32'h0000_0080);
    look("nt_miss_noalloc", 32'h0000_0010, 1'b0, 32'h0);
    chk("nt_miss_ctr", 32'(dut.ctr_q[4]), 32'd2);
    chk("alias_br", BrCount, 32'd7);
    chk("alias_mis", MispredCount, 32'd3);

    // Same-cycle lookup and update of one PC
    PCF         = 32'h0000_0090;
    UpdValidE   = 1'b1;
    UpdPCE      = 32'h0000_0090;
    UpdTakenE   = 1'b1;
    UpdTargetE  = 32'h0000_00A0;
    UpdMispredE = 1'b1;
    #1;
    chk("rw_same.taken", {31'b0, PredTakenF}, 32'd0);
    chk("rw_same.target", PredTargetF, 32'h0);
    step();
    UpdValidE   = 1'b0;
    UpdMispredE = 1'b0;
    look("rw_next", 32'h0000_0090, 1'b1, 32'h0000_00A0);

    // Taken hit overwrites target
    upd(32'h0000_0090, 1'b1, 32'h0000_00B0, 1'b0);
    look("tgt_overwrite", 32'h0000_0090, 1'b1, 32'h0000_00B0);
    chk("tgt_overwrite_ctr", 32'(dut.ctr_q[4]), 32'd3);
    chk("rw_br", BrCount, 32'd9);
    chk("rw_mis", MispredCount, 32'd4);

    // Mispredict flag without a valid update is ignored
    UpdMispredE = 1'b1;
    step();
    UpdMispredE = 1'b0;
    chk("mis_novalid_mis", MispredCount, 32'd4);
    chk("mis_novalid_br", BrCount, 32'd9);

    // Branch counter wrap
    force dut.br_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_count_q;
    chk("wrap_preload", BrCount, 32'hFFFF_FFFF);
    upd(32'h0000_0200, 1'b0, 32'h0, 1'b1);
    chk("wrap_br", BrCount, 32'h0);
    chk("wrap_mis", MispredCount, 32'd5);

    // Reset with a simultaneous update after several allocations
    upd(32'h0000_0100, 1'b1, 32'h0000_1000, 1'b0);
    upd(32'h0000_0104, 1'b1, 32'h0000_1004, 1'b1);
    upd(32'h0000_0108, 1'b1, 32'h0000_1008, 1'b0);
    look("pre_rst_hit", 32'h0000_0104, 1'b1, 32'h0000_1004);
    rst = 1'b1;
    upd(32'h0000_010C, 1'b1, 32'h0000_100C, 1'b1);
    rst = 1'b0;
    look("rst_0x100", 32'h0000_0100, 1'b0, 32'h0);
    look("rst_0x104", 32'h0000_0104, 1'b0, 32'h0);
    look("rst_0x108", 32'h0000_0108, 1'b0, 32'h0);
    look("rst_0x10c", 32'h0000_010C, 1'b0, 32'h0);
    look("rst_0x90", 32'h0000_0090, 1'b0, 32'h0);
    chk("rst_ctr4", 32'(dut.ctr_q[4]), 32'd0);
    chk("rst_br", BrCount, 32'd0);
    chk("rst_mis", MispredCount, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
